mux_n_to_1_pipe: RTL and testbench

//   Parametrised N-input, WIDTH-bit selector with a registered, back-pressurable output.

---
 rtl/otter_mux_pkg.sv | 15 +
 rtl/mux_n_to_1_pipe_skid.sv | 84 ++++++++
 rtl/mux_n_to_1_pipe.sv | 72 +++++++
 tb/tb_mux_n_to_1_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_mux_pkg.sv
// Shared types and helpers for the pipelined N-to-1 select mux.
//   mux_state_t   : occupancy state of the 2-entry output buffer
//   sel_in_range  : 1 when a select index addresses a real input
//   MAX_N_IN      : largest supported number of inputs
package otter_mux_pkg;

  localparam int MAX_N_IN = 16;

  typedef enum logic [1:0] {MX_EMPTY, MX_ONE, MX_FULL} mux_state_t;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/mux_n_to_1_pipe_skid.sv
// skid_buf_2: 2-entry valid/ready buffer (main register + skid register).
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   data_i/valid_i    : upstream word and valid
//   ready_o           : registered; low only while both entries are occupied
//   data_o/valid_o    : main register contents and its valid
//   ready_i           : downstream accepts data_o this cycle
module skid_buf_2
  import otter_mux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  mux_state_t       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             accept, drain;

  assign valid_o = (state_q != MX_EMPTY);
  assign data_o  = main_q;
  assign ready_o = ready_q;

  assign accept = valid_i & ready_q;
  assign drain  = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      MX_EMPTY: begin
        if (accept) begin
          main_d  = data_i;
          state_d = MX_ONE;
        end
      end
      MX_ONE: begin
        if (accept && drain) begin
          main_d = data_i;
        end else if (accept) begin
          skid_d  = data_i;
          state_d = MX_FULL;
        end else if (drain) begin
          state_d = MX_EMPTY;
        end
      end
      MX_FULL: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = MX_ONE;
        end
      end
      default: state_d = MX_EMPTY;
    endcase
    // Ready is decoded from the next state and registered, so it never
    // depends combinationally on ready_i; it stays low through reset and
    // rises on the first edge after release.
    ready_d = (state_d != MX_FULL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MX_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// mux_n_to_1_pipe: N_IN-input, WIDTH-bit selector with a registered,
// back-pressurable output and a sticky out-of-range-select flag.
//   CLK, RST            : clock, asynchronous active-high reset
//   in_data             : packed inputs, input k = in_data[k*WIDTH +: WIDTH]
//   sel                 : input index, sampled with in_data on accept
//   in_valid/in_ready   : upstream handshake
//   out_data/out_valid  : registered selected word
//   out_ready           : downstream handshake
//   sel_err             : sticky, set by accepting an out-of-range sel
//   clr_err             : synchronous clear of sel_err (set wins)
module mux_n_to_1_pipe
  import otter_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 5,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  clr_err
);

  if (N_IN < 2 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("mux_n_to_1_pipe: N_IN must be in 2..%0d", MAX_N_IN);
  end

  logic             in_range;
  logic             accept;
  logic [WIDTH-1:0] word;
  logic             sel_err_q, sel_err_d;

  assign in_range = sel_in_range(32'(sel), 32'(N_IN));
  assign accept   = in_valid & in_ready;

  // Out-of-range selects fall back to input 0.
  always_comb begin
    word = in_data[0 +: WIDTH];
    for (int unsigned k = 1; k < N_IN; k++) begin
      if (in_range && sel == SEL_W'(k)) word = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Set term is gated by accept so an undriven sel while idle cannot leak in.
  assign sel_err_d = (accept & ~in_range) | (sel_err_q & ~clr_err);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  skid_buf_2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .data_i  (word),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .ready_i (out_ready)
  );

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
module tb_mux_n_to_1_pipe;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [159:0]  in_data;
  logic [2:0]    sel;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          sel_err;
  logic          clr_err = 1'b0;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [31:0]   tbl [5];
  logic [31:0]   sb [$];
  bit            err_m = 1'b0;
  bit            sw_go = 1'b0;

  always #5 clk = ~clk;

  mux_n_to_1_pipe #(.WIDTH(32), .N_IN(5)) u_dut (
    .CLK(clk), .RST(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .clr_err(clr_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; predict what the next
  // rising edge accepts and push it onto the scoreboard.
  task automatic cycle(input bit v, input int s, input bit r, input bit c);
    @(negedge clk);
    chk("in_ready_occ", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    in_valid  = v;
    out_ready = r;
    clr_err   = c;
    if (v) sel = 3'(s);
    else   sel = 'x;
    if (v && in_ready) begin
      sb.push_back((s < 5) ? tbl[s] : tbl[0]);
      err_m = (s >= 5) | (err_m & ~c);
    end else begin
      err_m = err_m & ~c;
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a drain happens at the coming edge when out_valid & out_ready.
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_unexpected: got %h expected no word", out_data);
      end else begin
        chk("drain_data", {32'd0, out_data}, {32'd0, sb.pop_front()});
      end
    end
  end

  // Parameter sweep instances with random valid/ready.
  localparam int SW_N [3] = '{2, 8, 16};
  localparam int SW_W [3] = '{64, 8, 64};

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int N  = SW_N[g];
    localparam int W  = SW_W[g];
    localparam int SW = $clog2(N);
    logic [N*W-1:0] d = '0;
    logic [SW-1:0]  s = '0;
    logic           v = 1'b0;
    logic           orr = 1'b0;
    logic           ir, ov, se;
    logic [W-1:0]   od;
    logic [W-1:0]   q [$];
    logic [63:0]    words [16];
    bit             done = 1'b0;

    mux_n_to_1_pipe #(.WIDTH(W), .N_IN(N)) u_sw (
      .CLK(clk), .RST(rst), .in_data(d), .sel(s), .in_valid(v),
      .in_ready(ir), .out_data(od), .out_valid(ov),
      .out_ready(orr), .sel_err(se), .clr_err(1'b0)
    );

    initial begin
      wait (sw_go);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        chk($sformatf("sw%0d_in_ready", g), {63'd0, ir}, {63'd0, q.size() < 2});
        chk($sformatf("sw%0d_out_valid", g), {63'd0, ov}, {63'd0, q.size() != 0});
        for (int k = 0; k < N; k++) begin
          words[k] = {$urandom, $urandom};
          d[k*W +: W] = W'(words[k]);
        end
        s   = SW'($urandom_range(0, N - 1));
        v   = ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 2) != 0);
        if (v && ir) q.push_back(W'(words[s]));
      end
      @(negedge clk);
      v   = 1'b0;
      orr = 1'b1;
      repeat (6) @(negedge clk);
      chk($sformatf("sw%0d_left", g), 64'(q.size()), 64'd0);
      chk($sformatf("sw%0d_sel_err", g), {63'd0, se}, 64'd0);
      done = 1'b1;
    end

    always begin
      @(negedge clk);
      #1;
      if (!rst && ov && orr) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sw%0d_drain_unexpected: got %h expected no word", g, od);
        end else begin
          chk($sformatf("sw%0d_data", g), 64'(od), 64'(q.pop_front()));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      tbl[k] = 32'h11 * (k + 1);
      in_data[k*32 +: 32] = tbl[k];
    end
    sel = 'x;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1. reset mid-run, then one word
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    peek();
    #3;
    rst = 1'b1;
    sb.delete();
    err_m = 1'b0;
    #1;
    chk("t1_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t1_rst_data", {32'd0, out_data}, 64'd0);
    chk("t1_rst_err", {63'd0, sel_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    peek();
    chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
    cycle(1, 3, 1, 0);
    peek();
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_data", {32'd0, out_data}, 64'h44);

    // 2. streaming
    for (int s = 0; s < 5; s++) cycle(1, s, 1, 0);
    cycle(0, 0, 1, 0);
    peek();
    chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
    cycle(0, 0, 1, 0);
    peek();
    chk("t2_empty", {63'd0, out_valid}, 64'd0);

    // 3. back-pressure
    cycle(1, 1, 0, 0);
    cycle(1, 2, 0, 0);
    peek();
    chk("t3_full_ready", {63'd0, in_ready}, 64'd0);
    chk("t3_full_data", {32'd0, out_data}, 64'h22);
    cycle(1, 3, 0, 0);
    peek();
    chk("t3_held_data", {32'd0, out_data}, 64'h22);
    chk("t3_held_ready", {63'd0, in_ready}, 64'd0);
    cycle(0, 0, 1, 0);
    peek();
    chk("t3_rel_data", {32'd0, out_data}, 64'h33);
    chk("t3_rel_ready", {63'd0, in_ready}, 64'd1);
    cycle(0, 0, 1, 0);
    peek();
    chk("t3_empty", {63'd0, out_valid}, 64'd0);

    // 4. range error
    cycle(1, 6, 1, 0);
    peek();
    chk("t4_data", {32'd0, out_data}, 64'h11);
    chk("t4_set", {63'd0, sel_err}, {63'd0, err_m});
    cycle(1, 2, 1, 0);
    peek();
    chk("t4_sticky", {63'd0, sel_err}, {63'd0, err_m});
    cycle(1, 7, 1, 1);
    peek();
    chk("t4_set_wins", {63'd0, sel_err}, 64'd1);
    cycle(0, 0, 1, 1);
    peek();
    chk("t4_clear", {63'd0, sel_err}, {63'd0, err_m});
    cycle(0, 0, 1, 0);

    // 5. reset while FULL
    cycle(1, 0, 0, 0);
    cycle(1, 4, 0, 0);
    peek();
    chk("t5_full", {63'd0, in_ready}, 64'd0);
    #3;
    rst = 1'b1;
    sb.delete();
    err_m = 1'b0;
    in_valid = 1'b0;
    sel = 'x;
    #1;
    chk("t5_async_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_async_data", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0);
      peek();
      chk("t5_no_stale", {63'd0, out_valid}, 64'd0);
    end
    cycle(1, 2, 1, 0);
    peek();
    chk("t5_after", {32'd0, out_data}, 64'h33);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("t5_left", 64'(sb.size()), 64'd0);

    // 6. parameter sweep
    sw_go = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (g_sw[0].done && g_sw[1].done && g_sw[2].done) break;
      @(negedge clk);
    end
    chk("sw_complete", {63'd0, g_sw[0].done && g_sw[1].done && g_sw[2].done}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
